hsv_core_issue_dispatch: RTL and testbench

- Parametrised issue-stage dispatcher. Accepts one issue transaction per cycle from decode and routes it to one of NUM_UNITS execution-unit channels (ALU, MEM, BRANCH, CSR, ...).
- Each channel has its own 2-entry skid buffer, so a stalled unit never blocks traffic that is already buffered for other units.
- Supports a flush handshake with the pipeline controller, invalid-unit detection and an accepted-issue counter.
- Sits between the decode stage and the exec-mem processing units.

---
 rtl/hsv_core_issue_dispatch_if.sv | 25 ++
 rtl/hsv_core_issue_dispatch.sv | 82 ++++++++
 tb/tb_hsv_core_issue_dispatch.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/hsv_core_issue_dispatch_if.sv
// rtl/hsv_core_issue_dispatch_if.sv - issue-side and unit-side handshake bundle for the dispatcher
interface hsv_core_issue_dispatch_if #(
  parameter int NUM_UNITS = 4,
  parameter int DATA_W    = 64,
  parameter int SEL_W     = $clog2(NUM_UNITS)
);
  logic                        valid_i;
  logic                        ready_o;
  logic [DATA_W-1:0]           data_i;
  logic [SEL_W-1:0]            unit_i;
  logic [NUM_UNITS-1:0]        valid_o;
  logic [NUM_UNITS-1:0]        ready_i;
  logic [NUM_UNITS*DATA_W-1:0] data_o;

  // master: decode stage plus execution units; slave: the dispatcher
  modport master (
    output valid_i, data_i, unit_i, ready_i,
    input  ready_o, valid_o, data_o
  );

  modport slave (
    input  valid_i, data_i, unit_i, ready_i,
    output ready_o, valid_o, data_o
  );
endinterface

// File: rtl/hsv_core_issue_dispatch.sv
// rtl/hsv_core_issue_dispatch.sv - routes issue transactions to per-unit channels with 2-entry skid buffers
module hsv_core_issue_dispatch #(
  parameter int NUM_UNITS = 4,
  parameter int DATA_W    = 64,
  parameter int SEL_W     = $clog2(NUM_UNITS),
  parameter int CNT_W     = 16
) (
  input  logic                          clk_core,
  input  logic                          rst_core,
  input  logic                          flush_req,
  output logic                          flush_ack,
  hsv_core_issue_dispatch_if.slave      bus,
  output logic                          err_unit_o,
  output logic [CNT_W-1:0]              issue_count_o
);

  logic [NUM_UNITS-1:0] out_valid;
  logic [NUM_UNITS-1:0] skid_valid;
  logic [DATA_W-1:0]    out_data  [NUM_UNITS];
  logic [DATA_W-1:0]    skid_data [NUM_UNITS];

  logic [NUM_UNITS-1:0] sel;
  logic [NUM_UNITS-1:0] accept;
  logic                 unit_valid;

  assign unit_valid = ({1'b0, bus.unit_i} < (SEL_W+1)'(NUM_UNITS));

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_chan
    assign sel[u] = (bus.unit_i == SEL_W'(u));
    assign bus.data_o[u*DATA_W +: DATA_W] = out_data[u];
  end

  // Channel readiness comes only from registered skid state, so ready_o
  // never sees a combinational path from the units' ready_i.
  assign accept      = (bus.valid_i && !flush_req) ? (sel & ~skid_valid) : '0;
  assign bus.ready_o = !flush_req && (!unit_valid || ((sel & ~skid_valid) != '0));
  assign bus.valid_o = out_valid;

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      out_valid     <= '0;
      skid_valid    <= '0;
      flush_ack     <= 1'b0;
      err_unit_o    <= 1'b0;
      issue_count_o <= '0;
      for (int u = 0; u < NUM_UNITS; u++) begin
        out_data[u]  <= '0;
        skid_data[u] <= '0;
      end
    end else begin
      flush_ack  <= flush_req;
      err_unit_o <= bus.valid_i && !flush_req && !unit_valid;
      if (accept != '0)
        issue_count_o <= issue_count_o + 1'b1;

      if (flush_req) begin
        out_valid  <= '0;
        skid_valid <= '0;
      end else begin
        for (int u = 0; u < NUM_UNITS; u++) begin
          if (bus.ready_i[u] || !out_valid[u]) begin
            // Skid entry is older than any new input, so it drains first.
            if (skid_valid[u]) begin
              out_data[u]  <= skid_data[u];
              out_valid[u] <= 1'b1;
            end else if (accept[u]) begin
              out_data[u]  <= bus.data_i;
              out_valid[u] <= 1'b1;
            end else begin
              out_valid[u] <= 1'b0;
            end
            skid_valid[u] <= 1'b0;
          end else if (accept[u]) begin
            skid_data[u]  <= bus.data_i;
            skid_valid[u] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hsv_core_issue_dispatch.sv
// tb/tb_hsv_core_issue_dispatch.sv - directed self-checking bench for hsv_core_issue_dispatch
module tb_hsv_core_issue_dispatch;

  logic        clk;
  logic        rst;
  logic        flush_req_a, flush_ack_a, err_a;
  logic [15:0] cnt_a;
  logic        flush_req_b, flush_ack_b, err_b;
  logic [3:0]  cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  hsv_core_issue_dispatch_if #(.NUM_UNITS(4), .DATA_W(64)) ifa ();
  hsv_core_issue_dispatch_if #(.NUM_UNITS(3), .DATA_W(64)) ifb ();

  hsv_core_issue_dispatch #(.NUM_UNITS(4), .DATA_W(64), .CNT_W(16)) dut_a (
    .clk_core      (clk),
    .rst_core      (rst),
    .flush_req     (flush_req_a),
    .flush_ack     (flush_ack_a),
    .bus           (ifa),
    .err_unit_o    (err_a),
    .issue_count_o (cnt_a)
  );

  hsv_core_issue_dispatch #(.NUM_UNITS(3), .DATA_W(64), .CNT_W(4)) dut_b (
    .clk_core      (clk),
    .rst_core      (rst),
    .flush_req     (flush_req_b),
    .flush_ack     (flush_ack_b),
    .bus           (ifb),
    .err_unit_o    (err_b),
    .issue_count_o (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] chan_a(input int u);
    return ifa.data_o[u*64 +: 64];
  endfunction

  initial begin
    rst = 1'b1;
    flush_req_a = 1'b0; flush_req_b = 1'b0;
    ifa.valid_i = 1'b0; ifa.data_i = '0; ifa.unit_i = '0; ifa.ready_i = 4'hF;
    ifb.valid_i = 1'b0; ifb.data_i = '0; ifb.unit_i = '0; ifb.ready_i = 3'h7;
    tick(); tick();
    rst = 1'b0;
    check("rst_valid_o", 64'(ifa.valid_o), 64'h0);
    check("rst_count",   64'(cnt_a), 64'h0);
    check("rst_ack",     64'(flush_ack_a), 64'h0);
    check("rst_err",     64'(err_a), 64'h0);
    check("rst_data_o",  ifa.data_o[255:0] == '0 ? 64'h1 : 64'h0, 64'h1);

    // Stream to unit 2
    ifa.valid_i = 1'b1; ifa.unit_i = 2'd2;
    for (int i = 0; i < 3; i++) begin
      ifa.data_i = 64'h10 + 64'(i);
      tick();
      check("stream_valid", 64'(ifa.valid_o), 64'h4);
      check("stream_data",  chan_a(2), 64'h10 + 64'(i));
    end
    ifa.valid_i = 1'b0;
    tick();
    check("stream_idle",  64'(ifa.valid_o), 64'h0);
    check("stream_count", 64'(cnt_a), 64'd3);

    // Backpressure on unit 1
    ifa.ready_i = 4'b1101;
    ifa.valid_i = 1'b1; ifa.unit_i = 2'd1; ifa.data_i = 64'hA;
    tick();
    check("bp_first_valid", 64'(ifa.valid_o), 64'h2);
    check("bp_first_data",  chan_a(1), 64'hA);
    ifa.data_i = 64'hB;
    tick();
    check("bp_hold_valid", 64'(ifa.valid_o), 64'h2);
    check("bp_hold_data",  chan_a(1), 64'hA);
    ifa.valid_i = 1'b0;
    #1;
    check("bp_ready_u1", 64'(ifa.ready_o), 64'h0);
    ifa.unit_i = 2'd0;
    #1;
    check("bp_ready_u0", 64'(ifa.ready_o), 64'h1);
    ifa.valid_i = 1'b1; ifa.data_i = 64'hC;
    tick();
    check("bp_u0_valid", 64'(ifa.valid_o), 64'h3);
    check("bp_u0_data",  chan_a(0), 64'hC);
    check("bp_u1_still", chan_a(1), 64'hA);
    ifa.valid_i = 1'b0; ifa.ready_i = 4'hF;
    tick();
    check("bp_drain_valid", 64'(ifa.valid_o), 64'h2);
    check("bp_drain_data",  chan_a(1), 64'hB);
    tick();
    check("bp_empty", 64'(ifa.valid_o), 64'h0);
    check("bp_count", 64'(cnt_a), 64'd6);

    // Interleaved 0,1,2,3,0
    ifa.valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ifa.unit_i = 2'(i % 4);
      ifa.data_i = 64'h20 + 64'(i);
      tick();
      check("ilv_valid", 64'(ifa.valid_o), 64'(4'b0001 << (i % 4)));
      check("ilv_data",  chan_a(i % 4), 64'h20 + 64'(i));
    end
    ifa.valid_i = 1'b0;
    tick();
    check("ilv_count", 64'(cnt_a), 64'd11);

    // Flush with unit 3 stalled holding two entries
    ifa.ready_i = 4'b0111;
    ifa.valid_i = 1'b1; ifa.unit_i = 2'd3;
    ifa.data_i = 64'h30; tick();
    ifa.data_i = 64'h31; tick();
    ifa.valid_i = 1'b0;
    #1;
    check("fl_stall_valid", 64'(ifa.valid_o), 64'h8);
    check("fl_stall_data",  chan_a(3), 64'h30);
    check("fl_stall_ready", 64'(ifa.ready_o), 64'h0);
    flush_req_a = 1'b1;
    ifa.valid_i = 1'b1; ifa.unit_i = 2'd0; ifa.data_i = 64'h40;
    #1;
    check("fl_ready_low", 64'(ifa.ready_o), 64'h0);
    tick();
    flush_req_a = 1'b0; ifa.valid_i = 1'b0; ifa.unit_i = 2'd3;
    #1;
    check("fl_valid_clear", 64'(ifa.valid_o), 64'h0);
    check("fl_ack_high",    64'(flush_ack_a), 64'h1);
    check("fl_skid_empty",  64'(ifa.ready_o), 64'h1);
    tick();
    check("fl_ack_low", 64'(flush_ack_a), 64'h0);
    check("fl_valid_0", 64'(ifa.valid_o), 64'h0);
    check("fl_count",   64'(cnt_a), 64'd13);
    ifa.ready_i = 4'hF;

    // Invalid unit on the 3-channel instance
    ifb.valid_i = 1'b1; ifb.unit_i = 2'd3; ifb.data_i = 64'h55;
    #1;
    check("inv_ready", 64'(ifb.ready_o), 64'h1);
    tick();
    ifb.valid_i = 1'b0;
    check("inv_err",   64'(err_b), 64'h1);
    check("inv_valid", 64'(ifb.valid_o), 64'h0);
    check("inv_count", 64'(cnt_b), 64'h0);
    tick();
    check("inv_err_pulse", 64'(err_b), 64'h0);

    // Counter wrap, with dut_a stalled on unit 1 to exercise reset mid-stall
    ifa.ready_i = 4'b1101; ifa.valid_i = 1'b1; ifa.unit_i = 2'd1; ifa.data_i = 64'h77;
    ifb.valid_i = 1'b1; ifb.unit_i = 2'd0;
    for (int i = 0; i < 17; i++) begin
      ifb.data_i = 64'(i);
      tick();
      if (i == 15) check("wrap_zero", 64'(cnt_b), 64'h0);
    end
    check("wrap_one", 64'(cnt_b), 64'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifa.valid_i = 1'b0; ifb.valid_i = 1'b0;
    #1;
    check("mrst_b_valid", 64'(ifb.valid_o), 64'h0);
    check("mrst_b_count", 64'(cnt_b), 64'h0);
    check("mrst_b_data",  ifb.data_o[63:0], 64'h0);
    check("mrst_a_valid", 64'(ifa.valid_o), 64'h0);
    check("mrst_a_count", 64'(cnt_a), 64'h0);
    check("mrst_a_skid",  64'(ifa.ready_o), 64'h1);
    check("mrst_a_ack",   64'(flush_ack_a), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
